// File: rtl/memory_arbiter_2p.sv
// Two-requester round-robin arbiter in front of a single-port valid/ready memory.
// One access at a time: IDLE -> BUSY (memory handshake, timeout guard) -> RESP (one-cycle reply) -> IDLE.
module memory_arbiter_2p #(
    parameter int MEMORY_WIDTH   = 8,
    parameter int MEMORY_DEPTH   = 16,
    parameter int ADDRESS_WIDTH  = $clog2(MEMORY_DEPTH),
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 req_valid_i,
    input  logic [1:0]                 req_wr_rd_i,
    input  logic [2*ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [2*MEMORY_WIDTH-1:0]  req_wdata_i,
    output logic [1:0]                 req_ready_o,
    output logic [1:0]                 req_err_o,
    output logic [MEMORY_WIDTH-1:0]    req_rdata_o,
    output logic                       mem_valid_o,
    output logic                       mem_wr_rd_o,
    output logic [ADDRESS_WIDTH-1:0]   mem_addr_o,
    output logic [MEMORY_WIDTH-1:0]    mem_wdata_o,
    input  logic                       mem_ready_i,
    input  logic [MEMORY_WIDTH-1:0]    mem_rdata_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]               state;
    logic                     last_grant;
    logic                     grant;
    logic [CNT_W-1:0]         tmo_cnt;
    logic                     sel;
    logic                     sel_wr_rd;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [MEMORY_WIDTH-1:0]  sel_wdata;
    logic [1:0]               grant_onehot;

    // Round-robin pick: on contention the requester not served last time wins.
    always_comb begin
        sel = 1'b0;
        if (req_valid_i == 2'b11) begin
            sel = ~last_grant;
        end else begin
            sel = req_valid_i[1];
        end
        sel_wr_rd = req_wr_rd_i[sel];
        sel_addr  = sel ? req_addr_i[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                        : req_addr_i[ADDRESS_WIDTH-1:0];
        sel_wdata = sel ? req_wdata_i[2*MEMORY_WIDTH-1:MEMORY_WIDTH]
                        : req_wdata_i[MEMORY_WIDTH-1:0];
    end

    assign grant_onehot = grant ? 2'b10 : 2'b01;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            tmo_cnt     <= '0;
            req_ready_o <= 2'b00;
            req_err_o   <= 2'b00;
            req_rdata_o <= '0;
            mem_valid_o <= 1'b0;
            mem_wr_rd_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        grant       <= sel;
                        last_grant  <= sel;
                        mem_valid_o <= 1'b1;
                        mem_wr_rd_o <= sel_wr_rd;
                        mem_addr_o  <= sel_addr;
                        mem_wdata_o <= sel_wdata;
                        tmo_cnt     <= '0;
                        state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A memory accept in the last allowed cycle still completes normally.
                    if (mem_ready_i) begin
                        mem_valid_o <= 1'b0;
                        req_ready_o <= grant_onehot;
                        if (!mem_wr_rd_o) begin
                            req_rdata_o <= mem_rdata_i;
                        end
                        state <= ST_RESP;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_valid_o <= 1'b0;
                        req_ready_o <= grant_onehot;
                        req_err_o   <= grant_onehot;
                        req_rdata_o <= '0;
                        state       <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    req_ready_o <= 2'b00;
                    req_err_o   <= 2'b00;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter_2p.sv
// Bench for memory_arbiter_2p: directed vector table, contention, reset-in-flight and
// randomized traffic checked against a transaction-level reference model.
module tb_memory_arbiter_2p;

    localparam int MW  = 8;
    localparam int AW  = 4;
    localparam int TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [1:0]    req_valid_i = '0;
    logic [1:0]    req_wr_rd_i = '0;
    logic [2*AW-1:0] req_addr_i = '0;
    logic [2*MW-1:0] req_wdata_i = '0;
    logic [1:0]    req_ready_o;
    logic [1:0]    req_err_o;
    logic [MW-1:0] req_rdata_o;
    logic          mem_valid_o;
    logic          mem_wr_rd_o;
    logic [AW-1:0] mem_addr_o;
    logic [MW-1:0] mem_wdata_o;
    logic          mem_ready_i = 1'b0;
    logic [MW-1:0] mem_rdata_i = '0;

    memory_arbiter_2p #(
        .MEMORY_WIDTH(MW), .MEMORY_DEPTH(16), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_wr_rd_i(req_wr_rd_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_ready_o(req_ready_o), .req_err_o(req_err_o), .req_rdata_o(req_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_wr_rd_o(mem_wr_rd_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
    } txn_t;

    typedef struct {
        int            id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] data;
        int            lat;
        logic [1:0]    e_ready;
        logic [1:0]    e_err;
        logic [MW-1:0] e_rdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    txn_t rq0[$];
    txn_t rq1[$];
    int   order[$];
    bit   active[2];
    int   gap[2];
    int   gap_max;
    int   force_lat;
    bit   free_m, skip_m, last_m, pend_valid, fv_seen;
    int   pend_w, pend_cyc, cur_lat, wcnt, vcnt, cyc;
    txn_t pend_txn;
    logic [MW-1:0] model_mem [16];
    logic [MW-1:0] tb_mem [16];
    logic [MW-1:0] model_rdata;
    logic [1:0]    cap_ready, cap_err;
    logic [MW-1:0] cap_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int n, input bit v, input txn_t t);
        if (n == 0) begin
            req_valid_i[0] = v; req_wr_rd_i[0] = t.wr;
            req_addr_i[AW-1:0] = t.addr; req_wdata_i[MW-1:0] = t.data;
        end else begin
            req_valid_i[1] = v; req_wr_rd_i[1] = t.wr;
            req_addr_i[2*AW-1:AW] = t.addr; req_wdata_i[2*MW-1:MW] = t.data;
        end
    endtask

    function automatic txn_t head(input int n);
        txn_t t;
        t = '{1'b0, '0, '0};
        if (n == 0 && rq0.size() > 0) t = rq0[0];
        if (n == 1 && rq1.size() > 0) t = rq1[0];
        return t;
    endfunction

    task automatic model_reset();
        last_m = 1'b1; free_m = 1'b1; skip_m = 1'b0; pend_valid = 1'b0;
        model_rdata = '0; active[0] = 1'b0; active[1] = 1'b0;
        gap[0] = 0; gap[1] = 0; wcnt = 0; vcnt = 0; fv_seen = 1'b0;
    endtask

    // One clock of the traffic engine: observe, memory responder, requesters, model arbitration.
    task automatic step();
        logic [1:0]    rdy, er;
        logic [MW-1:0] rd;
        bit            tmo_exp;
        int            w, onehot;
        @(negedge clk_i);
        cyc++;
        if (skip_m) begin skip_m = 1'b0; free_m = 1'b1; end
        rdy = req_ready_o; er = req_err_o; rd = req_rdata_o;
        if (pend_valid && mem_valid_o) begin
            vcnt++;
            if (!fv_seen) begin
                fv_seen = 1'b1;
                chk("mem_addr", 32'(mem_addr_o), 32'(pend_txn.addr));
                chk("mem_wr_rd", 32'(mem_wr_rd_o), 32'(pend_txn.wr));
                if (pend_txn.wr) chk("mem_wdata", 32'(mem_wdata_o), 32'(pend_txn.data));
            end
        end
        if (rdy != 2'b00) begin
            tmo_exp = (cur_lat >= TMO);
            onehot  = pend_valid ? (1 << pend_w) : 0;
            chk("ready_owner", 32'(rdy), 32'(onehot));
            chk("err", 32'(er), tmo_exp ? 32'(onehot) : 32'd0);
            chk("latency", 32'(cyc - pend_cyc), tmo_exp ? 32'(TMO + 1) : 32'(cur_lat + 2));
            chk("valid_cycles", 32'(vcnt), tmo_exp ? 32'(TMO) : 32'(cur_lat + 1));
            if (tmo_exp) model_rdata = '0;
            else if (pend_txn.wr) model_mem[pend_txn.addr] = pend_txn.data;
            else model_rdata = model_mem[pend_txn.addr];
            chk("rdata", 32'(rd), 32'(model_rdata));
            cap_ready = rdy; cap_err = er; cap_rdata = rd;
            order.push_back(pend_w);
            if (pend_w == 0 && rq0.size() > 0) void'(rq0.pop_front());
            if (pend_w == 1 && rq1.size() > 0) void'(rq1.pop_front());
            active[pend_w] = 1'b0;
            gap[pend_w] = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            pend_valid = 1'b0;
            skip_m = 1'b1;
        end else begin
            chk("err_without_ready", 32'(er), 32'd0);
        end

        if (mem_valid_o) begin
            if (wcnt == cur_lat) begin
                mem_ready_i = 1'b1;
                if (mem_wr_rd_o) begin
                    tb_mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i = 8'($urandom);
                end else begin
                    mem_rdata_i = tb_mem[mem_addr_o];
                end
            end else begin
                mem_ready_i = 1'b0; mem_rdata_i = 8'($urandom); wcnt++;
            end
        end else begin
            mem_ready_i = 1'b0; mem_rdata_i = 8'($urandom); wcnt = 0;
        end

        for (int n = 0; n < 2; n++) begin
            if (!active[n] && ((n == 0) ? rq0.size() : rq1.size()) > 0) begin
                if (gap[n] == 0) begin drive(n, 1'b1, head(n)); active[n] = 1'b1; end
                else gap[n]--;
            end
            if (!active[n]) req_valid_i[n] = 1'b0;
        end

        if (free_m && (active[0] || active[1])) begin
            if (active[0] && active[1]) w = last_m ? 0 : 1;
            else w = active[1] ? 1 : 0;
            last_m = (w == 1); free_m = 1'b0; pend_valid = 1'b1;
            pend_w = w; pend_cyc = cyc; pend_txn = head(w);
            cur_lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 9));
            wcnt = 0; vcnt = 0; fv_seen = 1'b0;
        end
    endtask

    task automatic run(input int max_cycles);
        int i;
        for (i = 0; i < max_cycles; i++) begin
            if (rq0.size() == 0 && rq1.size() == 0 && !pend_valid) break;
            step();
        end
        chk("run_completed_in_budget", 32'(i < max_cycles), 32'd1);
        step();
        step();
    endtask

    vec_t vecs[9];

    initial begin
        int   pulses;
        txn_t t;
        vecs[0] = '{0, 1'b1, 4'd3, 8'h5A, 0,   2'b01, 2'b00, 8'h00};
        vecs[1] = '{1, 1'b0, 4'd3, 8'h00, 0,   2'b10, 2'b00, 8'h5A};
        vecs[2] = '{1, 1'b1, 4'd7, 8'hC3, 2,   2'b10, 2'b00, 8'h5A};
        vecs[3] = '{0, 1'b0, 4'd7, 8'h00, 1,   2'b01, 2'b00, 8'hC3};
        vecs[4] = '{0, 1'b0, 4'd3, 8'h00, 255, 2'b01, 2'b01, 8'h00};
        vecs[5] = '{1, 1'b0, 4'd3, 8'h00, 7,   2'b10, 2'b00, 8'h5A};
        vecs[6] = '{0, 1'b0, 4'd7, 8'h00, 8,   2'b01, 2'b01, 8'h00};
        vecs[7] = '{0, 1'b1, 4'd0, 8'h11, 3,   2'b01, 2'b00, 8'h00};
        vecs[8] = '{1, 1'b0, 4'd0, 8'h00, 0,   2'b10, 2'b00, 8'h11};
        for (int i = 0; i < 16; i++) begin
            tb_mem[i] = 8'(i * 13); model_mem[i] = 8'(i * 13);
        end
        cyc = 0; gap_max = 0; force_lat = 0; cur_lat = 0; pend_w = 0; pend_cyc = 0;
        pend_txn = '{1'b0, '0, '0};
        cap_ready = '0; cap_err = '0; cap_rdata = '0;
        model_reset();

        #1 rst_i = 1'b1;
        #2;
        chk("reset_ready", 32'(req_ready_o), 32'd0);
        chk("reset_err", 32'(req_err_o), 32'd0);
        chk("reset_rdata", 32'(req_rdata_o), 32'd0);
        chk("reset_mem_valid", 32'(mem_valid_o), 32'd0);
        chk("reset_mem_fields", 32'({mem_wr_rd_o, mem_addr_o, mem_wdata_o}), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 9; i++) begin
            t = '{vecs[i].wr, vecs[i].addr, vecs[i].data};
            if (vecs[i].id == 0) rq0.push_back(t); else rq1.push_back(t);
            force_lat = vecs[i].lat;
            cap_ready = '0; cap_err = '0; cap_rdata = 8'hEE;
            run(60);
            chk($sformatf("vec%0d_ready", i), 32'(cap_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_err", i), 32'(cap_err), 32'(vecs[i].e_err));
            chk($sformatf("vec%0d_rdata", i), 32'(cap_rdata), 32'(vecs[i].e_rdata));
        end

        order.delete();
        force_lat = 0; gap_max = 0;
        for (int i = 0; i < 2; i++) begin
            rq0.push_back('{1'b1, 4'(i + 8), 8'(8'hA0 + i)});
            rq1.push_back('{1'b0, 4'(i + 8), 8'h00});
        end
        run(100);
        chk("contention_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk($sformatf("contention_grant%0d", i), 32'(order[i]), 32'(i % 2));

        @(negedge clk_i);
        mem_ready_i = 1'b0;
        drive(0, 1'b1, '{1'b1, 4'd5, 8'h77});
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (req_ready_o != 2'b00) pulses++;
        end
        chk("stall_mem_valid", 32'(mem_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_mem_valid", 32'(mem_valid_o), 32'd0);
        chk("async_rst_ready", 32'(req_ready_o), 32'd0);
        chk("async_rst_mem_fields", 32'({mem_wr_rd_o, mem_addr_o, mem_wdata_o}), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        req_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            if (req_ready_o != 2'b00) pulses++;
        end
        chk("no_pulse_after_reset", 32'(pulses), 32'd0);

        model_reset();
        order.delete();
        force_lat = 0;
        rq0.push_back('{1'b0, 4'd1, 8'h00});
        rq1.push_back('{1'b0, 4'd2, 8'h00});
        run(60);
        chk("post_reset_count", 32'(order.size()), 32'd2);
        if (order.size() > 0) chk("post_reset_first_grant", 32'(order[0]), 32'd0);

        gap_max = 2; force_lat = -1;
        for (int i = 0; i < 30; i++) begin
            rq0.push_back('{1'($urandom), 4'($urandom), 8'($urandom)});
            rq1.push_back('{1'($urandom), 4'($urandom), 8'($urandom)});
        end
        run(4000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
